branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating counters for the pipelined core.
- Fetch stage: supplies a predicted next PC for the current fetch address.
- Execute stage: takes resolved control-flow outcomes from branch resolution, updates the table, and raises mispredict with a redirect PC.
- Mispredict drives the hazard unit's IF/ID and ID/EX flushes.

Parameters:
- XLEN, 64, data/PC width (matches DataBusBits)
- ENTRIES, 16, BTB entries, power of two, 2..256
- IDXW, log2(ENTRIES), index width, derived; index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  current fetch PC
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  XLEN  predicted target, valid when if_pred_taken=1
- ex_valid  in  1  EX holds a real instruction
- ex_stall  in  1  EX held this cycle; suppresses update and mispredict
- ex_ctrl  in  1  instruction is branch/jal/jalr
- ex_jump  in  1  instruction is jal/jalr
- ex_taken  in  1  resolved taken (jal|jalr|branchTaken)
- ex_target  in  XLEN  resolved target (PCNext when taken)
- ex_pc  in  XLEN  PC of EX instruction
- ex_pred_taken  in  1  prediction piped from IF
- ex_pred_target  in  XLEN  predicted target piped from IF
- mispredict  out  1  flush younger stages this cycle
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- perf_clear  in  1  synchronous clear of perf counters
- perf_ctrl_cnt  out  32  resolved control instructions
- perf_mispred_cnt  out  32  mispredicts

Behaviour:
- Entry: valid, tag, target[XLEN], jump bit, ctr[1:0].
- Reset (async, rst_n=0): all valid=0, ctr=2'b01, jump=0. Outputs during and after reset: if_pred_taken=0, if_pred_target=0, mispredict=0, redirect_pc=0, perf counters=0.
- Lookup (combinational, 0 latency): hit = valid & tag match at index(if_pc). if_pred_taken = hit & (jump | ctr[1]). if_pred_target = hit ? target : 0.
- upd = ex_valid & ~ex_stall.
- mispredict (combinational) = upd & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)). Non-control instructions use ex_taken=0.
- redirect_pc = ex_taken ? ex_target : ex_pc+4 (wraps mod 2^XLEN). redirect_pc=0 when mispredict=0.
- Table write at posedge clk when upd, indexed by ex_pc:
  - ex_ctrl & hit:
    - ctr increments on taken, decrements on not-taken; saturates at 3 and 0.
    - Taken: target <= ex_target, jump <= ex_jump.
  - ex_ctrl & miss & ex_taken: allocate (overwrites any entry at that index). valid=1, tag, target, jump=ex_jump, ctr=2'b10.
  - ex_ctrl & miss & ~ex_taken: no write.
  - ~ex_ctrl & ex_pred_taken (stale alias): entry at index invalidated (valid<=0).
- Same-cycle read/write of the same index: lookup returns the pre-write contents; no bypass.
- ex_stall=1: no write, no mispredict, no counter update; outputs hold their combinational value next cycle.
- Reset mid-operation: table cleared immediately, regardless of in-flight updates.

Optional Feature:
- BP_PERF_COUNTERS_EN defined:
  - perf_ctrl_cnt increments on each upd & ex_ctrl.
  - perf_mispred_cnt increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF.
  - perf_clear zeroes both next edge; perf_clear has priority over increment.
- BP_PERF_COUNTERS_EN undefined: no counter flops; both outputs tied to 0; perf_clear ignored.

Test Plan:
- Reset, then if_pc=0x100 → if_pred_taken=0. beq at ex_pc=0x100 resolved taken, ex_target=0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, target=0x80.
- Same branch resolved not-taken twice (ex_pred_taken=1 then 0) → first: mispredict=1, redirect_pc=0x104, ctr 2→1. Second: mispredict=0, ctr→0. Lookup 0x100 → pred_taken=0.
- jalr at 0x200: first target 0x400, then 0x500 with ex_pred_target=0x400 → second mispredict=1, redirect_pc=0x500. Lookup then gives 0x500 with pred_taken=1 regardless of ctr.
- 0x100 and 0x140 alias with ENTRIES=16 (tags differ) → allocating 0x140 evicts 0x100. Lookup 0x100 → miss, pred_taken=0.
- ex_stall=1 with mismatching outcome → mispredict=0, table unchanged. Deassert rst_n mid-stream → all lookups miss the following cycle.
- BP_PERF_COUNTERS_EN: 5 control resolves with 2 mispredicts → counts 5/2. perf_clear → 0/0. Without the macro → both read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; optional perf counters under BP_PERF_COUNTERS_EN.
// Latency: lookup and mispredict are combinational; the table updates on the next clk edge.
// Backpressure: ex_stall freezes table, counters and mispredict for that cycle.
module branch_predictor #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_ctrl,
  input  logic            ex_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            perf_clear,
  output logic [31:0]     perf_ctrl_cnt,
  output logic [31:0]     perf_mispred_cnt
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDXW-1:0] if_idx, ex_idx;
  logic [TAGW-1:0] if_tag, ex_tag;
  logic            if_hit, ex_hit, upd;

  assign if_idx = if_pc[IDXW+1:2];
  assign if_tag = if_pc[XLEN-1:IDXW+2];
  assign ex_idx = ex_pc[IDXW+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDXW+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd    = ex_valid && !ex_stall;

  assign if_pred_taken  = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
  assign if_pred_target = if_hit ? target_q[if_idx] : '0;

  assign mispredict  = upd && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = !mispredict ? '0 :
                       ex_taken    ? ex_target : ex_pc + XLEN'(4);

  // Reads above see the pre-write table; a same-index write lands at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (ex_ctrl) begin
        if (ex_hit) begin
          if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
            target_q[ex_idx] <= ex_target;
            jump_q[ex_idx]   <= ex_jump;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
          jump_q[ex_idx]   <= ex_jump;
          ctr_q[ex_idx]    <= 2'b10;
        end
      end else if (ex_pred_taken) begin
        // Non-control instruction was predicted taken: the entry aliases it.
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] ctrl_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else if (perf_clear) begin
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd && ex_ctrl && (ctrl_cnt_q != 32'hFFFF_FFFF))
        ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign perf_ctrl_cnt    = ctrl_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
  assign perf_ctrl_cnt     = '0;
  assign perf_mispred_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (XLEN=64, ENTRIES=16); expectations are hand-derived.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] if_pc = '0;
  logic        if_pred_taken;
  logic [63:0] if_pred_target;
  logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_ctrl = 1'b0, ex_jump = 1'b0;
  logic        ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [63:0] ex_target = '0, ex_pc = '0, ex_pred_target = '0;
  logic        mispredict;
  logic [63:0] redirect_pc;
  logic        perf_clear = 1'b0;
  logic [31:0] perf_ctrl_cnt, perf_mispred_cnt;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.XLEN(64), .ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_ctrl(ex_ctrl), .ex_jump(ex_jump),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_clear(perf_clear), .perf_ctrl_cnt(perf_ctrl_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_stall = 1'b0; ex_ctrl = 1'b0; ex_jump = 1'b0;
    ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_target = '0; ex_pc = '0; ex_pred_target = '0;
  endtask

  task automatic ex_set(input logic stall, input logic ctrl, input logic jump,
                        input logic taken, input logic [63:0] target, input logic [63:0] pc,
                        input logic ptaken, input logic [63:0] ptarget);
    ex_valid = 1'b1; ex_stall = stall; ex_ctrl = ctrl; ex_jump = jump;
    ex_taken = taken; ex_target = target; ex_pc = pc;
    ex_pred_taken = ptaken; ex_pred_target = ptarget;
    #1;
  endtask

  task automatic look(input string tag, input logic [63:0] pc, input logic pt,
                      input logic [63:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {63'd0, if_pred_taken}, {63'd0, pt});
    chk({tag, "_target"}, if_pred_target, tgt);
  endtask

  task automatic exp_ex(input string tag, input logic mp, input logic [63:0] rpc);
    chk({tag, "_mispredict"}, {63'd0, mispredict}, {63'd0, mp});
    chk({tag, "_redirect"}, redirect_pc, rpc);
  endtask

  initial begin
    // Reset state
    #12;
    look("rst", 64'h100, 1'b0, 64'h0);
    exp_ex("rst", 1'b0, 64'h0);
    chk("rst_perf_ctrl", {32'd0, perf_ctrl_cnt}, 64'd0);
    chk("rst_perf_misp", {32'd0, perf_mispred_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // beq at 0x100 taken to 0x80, predicted not-taken: allocate with ctr=2
    look("cold", 64'h100, 1'b0, 64'h0);
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h80, 64'h100, 1'b0, 64'h0);
    exp_ex("beq_alloc", 1'b1, 64'h80);
    tick(); idle();
    look("beq_hit", 64'h100, 1'b1, 64'h80);

    // Not-taken with prediction taken: ctr 2->1, redirect to fall-through
    ex_set(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h100, 1'b1, 64'h80);
    exp_ex("nt1", 1'b1, 64'h104);
    tick(); idle();
    look("nt1_look", 64'h100, 1'b0, 64'h80);
    // Correctly predicted not-taken: ctr 1->0, no mispredict
    ex_set(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h100, 1'b0, 64'h0);
    exp_ex("nt2", 1'b0, 64'h0);
    tick(); idle();
    // Saturate at 0, then one taken lifts ctr to 1 only: still predicts not-taken
    ex_set(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h100, 1'b0, 64'h0);
    tick();
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h80, 64'h100, 1'b0, 64'h80);
    exp_ex("tk_after_sat", 1'b1, 64'h80);
    tick(); idle();
    look("sat_low", 64'h100, 1'b0, 64'h80);

    // jalr at 0x200 (same index as 0x100): allocate, then retarget
    ex_set(1'b0, 1'b1, 1'b1, 1'b1, 64'h400, 64'h200, 1'b0, 64'h0);
    exp_ex("jalr1", 1'b1, 64'h400);
    tick(); idle();
    look("jalr1_look", 64'h200, 1'b1, 64'h400);
    ex_set(1'b0, 1'b1, 1'b1, 1'b1, 64'h500, 64'h200, 1'b1, 64'h400);
    exp_ex("jalr2", 1'b1, 64'h500);
    tick(); idle();
    look("jalr2_look", 64'h200, 1'b1, 64'h500);
    look("evicted_100", 64'h100, 1'b0, 64'h0);

    // Alias 0x100 / 0x140 share index 0 with different tags
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h80, 64'h100, 1'b0, 64'h0);
    tick();
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h90, 64'h140, 1'b0, 64'h0);
    tick(); idle();
    look("alias_100", 64'h100, 1'b0, 64'h0);
    look("alias_140", 64'h140, 1'b1, 64'h90);

    // Non-control instruction predicted taken: entry invalidated
    ex_set(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h140, 1'b1, 64'h90);
    exp_ex("stale", 1'b1, 64'h144);
    tick(); idle();
    look("stale_look", 64'h140, 1'b0, 64'h0);

    // Stall with a mismatching outcome: no mispredict, no write
    ex_set(1'b1, 1'b1, 1'b0, 1'b1, 64'h300, 64'h104, 1'b0, 64'h0);
    exp_ex("stall", 1'b0, 64'h0);
    tick(); idle();
    look("stall_look", 64'h104, 1'b0, 64'h0);
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h300, 64'h104, 1'b0, 64'h0);
    tick(); idle();
    look("unstall_look", 64'h104, 1'b1, 64'h300);

    // Fall-through wraps past the top of the address space
    ex_set(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h10);
    exp_ex("wrap", 1'b1, 64'h0);
    tick(); idle();

    // Control resolves so far: 11, mispredicts: 10
`ifdef BP_PERF_COUNTERS_EN
    chk("perf_ctrl", {32'd0, perf_ctrl_cnt}, 64'd11);
    chk("perf_misp", {32'd0, perf_mispred_cnt}, 64'd10);
    perf_clear = 1'b1;
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h300, 64'h104, 1'b0, 64'h0);
    tick(); idle();
    perf_clear = 1'b0;
    chk("perf_clr_ctrl", {32'd0, perf_ctrl_cnt}, 64'd0);
    chk("perf_clr_misp", {32'd0, perf_mispred_cnt}, 64'd0);
`else
    chk("perf_off_ctrl", {32'd0, perf_ctrl_cnt}, 64'd0);
    chk("perf_off_misp", {32'd0, perf_mispred_cnt}, 64'd0);
`endif

    // Async reset mid-stream with an update in flight
    ex_set(1'b0, 1'b1, 1'b0, 1'b1, 64'h600, 64'h104, 1'b1, 64'h300);
    rst_n = 1'b0;
    #1;
    idle();
    look("midrst_104", 64'h104, 1'b0, 64'h0);
    look("midrst_200", 64'h200, 1'b0, 64'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    look("postrst_104", 64'h104, 1'b0, 64'h0);
    chk("postrst_perf", {32'd0, perf_ctrl_cnt}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
